// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE controller: FSM states, opcodes,
// memory-latency constant and element-count derivation.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOADA,
    SWAP,
    LOADB,
    EXEC,
    OUT
  } state_e;

  typedef enum logic [1:0] {
    OP_DOT  = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  // Read data lands in the PE this many cycles after the grant cycle.
  localparam logic [2:0] LAT_CAPTURE = 3'd2;

  function automatic logic [4:0] len_from_dimen(input logic [1:0] dimen);
    return 5'd2 << dimen;
  endfunction

endpackage

// File: rtl/pe_ctrl_fetch.sv
// Operand fetch sequencer: request/grant handshake, capture latency tracking
// and element counter. Counters clear whenever the sequencer is disabled.
module pe_ctrl_fetch
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          gnt_i,
  input  logic [AW-1:0] base_i,
  input  logic [4:0]    len_i,
  output logic          rd_o,
  output logic [AW-1:0] addr_o,
  output logic [2:0]    lat_o,
  output logic          last_o
);

  logic [2:0] lat_q, lat_d;
  logic [4:0] idx_q, idx_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_q <= '0;
      idx_q <= '0;
    end else begin
      lat_q <= lat_d;
      idx_q <= idx_d;
    end
  end

  // Grants are only honoured while a request is outstanding (latency 0).
  always_comb begin
    lat_d = lat_q;
    idx_d = idx_q;
    if (!en_i) begin
      lat_d = '0;
      idx_d = '0;
    end else if (lat_q == '0) begin
      if (gnt_i) lat_d = 3'd1;
    end else if (lat_q == LAT_CAPTURE) begin
      lat_d = '0;
      idx_d = idx_q + 5'd1;
    end else begin
      lat_d = lat_q + 3'd1;
    end
  end

  assign rd_o   = en_i && (lat_q == '0);
  assign addr_o = rd_o ? (base_i + AW'(idx_q)) : '0;
  assign lat_o  = en_i ? lat_q : '0;
  assign last_o = en_i && (lat_q == LAT_CAPTURE) && (idx_q == len_i - 5'd1);

endmodule

// File: rtl/pe_controller.sv
// Command-driven sequencer for a vector PE: loads operands A and B from
// memory, runs DOT/ADD/SUB for LEN cycles and streams results out.
module pe_controller
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 16
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [1:0]             CMD_OP,
  input  logic [1:0]             CMD_DIMEN,
  input  logic [AW-1:0]          CMD_BASE_A,
  input  logic [AW-1:0]          CMD_BASE_B,
  output logic                   MEM_RD,
  input  logic                   MEM_GNT,
  output logic [AW-1:0]          MEM_ADDR,
  output logic                   RST_ADD,
  output logic                   RST_PC,
  output logic                   RST_ACC,
  output logic                   ADD_RST,
  output logic                   MAT_MUX,
  output logic                   WRITE_MAT,
  output logic                   MAC_CTRL,
  output logic                   ADD_CTRL,
  output logic                   ADD_INC,
  output logic                   ADD_STORE,
  output logic                   OUT_READY,
  output logic [2:0]             latency_counter,
  output logic [1:0]             DIMEN,
  output logic [$clog2(N)-1:0]   STORE_ADDRESS,
  output logic                   RES_VALID,
  input  logic                   RES_READY,
  output logic                   RES_LAST,
  output logic [$clog2(N)-1:0]   RES_INDEX,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [1:0]    dimen_q, dimen_d;
  logic [AW-1:0] base_a_q, base_a_d;
  logic [AW-1:0] base_b_q, base_b_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    len;
  logic          cmd_ready;
  logic          fetch_en;
  logic          fetch_last;

  assign len = len_from_dimen(dimen_q);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      op_q     <= OP_DOT;
      dimen_q  <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dimen_q  <= dimen_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fetch_en = (state_q == LOADA) || (state_q == LOADB);

  pe_ctrl_fetch #(
    .AW (AW)
  ) u_fetch (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .en_i   (fetch_en),
    .gnt_i  (MEM_GNT),
    .base_i ((state_q == LOADA) ? base_a_q : base_b_q),
    .len_i  (len),
    .rd_o   (MEM_RD),
    .addr_o (MEM_ADDR),
    .lat_o  (latency_counter),
    .last_o (fetch_last)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    dimen_d       = dimen_q;
    base_a_d      = base_a_q;
    base_b_d      = base_b_q;
    cnt_d         = '0;
    cmd_ready     = 1'b0;
    RST_ADD       = 1'b0;
    RST_PC        = 1'b0;
    RST_ACC       = 1'b0;
    ADD_RST       = 1'b0;
    MAT_MUX       = 1'b0;
    WRITE_MAT     = 1'b0;
    MAC_CTRL      = 1'b0;
    ADD_CTRL      = 1'b0;
    ADD_INC       = 1'b0;
    ADD_STORE     = 1'b0;
    OUT_READY     = 1'b0;
    RES_VALID     = 1'b0;
    RES_LAST      = 1'b0;
    RES_INDEX     = '0;
    STORE_ADDRESS = '0;
    DONE          = 1'b0;
    ERR           = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (CMD_VALID) begin
          if (CMD_OP == OP_RSVD) begin
            ERR = 1'b1;
          end else begin
            op_d     = op_e'(CMD_OP);
            dimen_d  = CMD_DIMEN;
            base_a_d = CMD_BASE_A;
            base_b_d = CMD_BASE_B;
            state_d  = INIT;
          end
        end
      end
      INIT: begin
        RST_ADD = 1'b1;
        RST_PC  = 1'b1;
        RST_ACC = 1'b1;
        ADD_RST = 1'b1;
        state_d = LOADA;
      end
      LOADA: begin
        WRITE_MAT = 1'b1;
        MAT_MUX   = 1'b1;
        if (fetch_last) state_d = SWAP;
      end
      SWAP: begin
        RST_ADD = 1'b1;
        state_d = LOADB;
      end
      LOADB: begin
        WRITE_MAT = 1'b1;
        if (fetch_last) state_d = EXEC;
      end
      EXEC: begin
        if (op_q == OP_DOT) begin
          MAC_CTRL = 1'b1;
        end else begin
          ADD_INC  = 1'b1;
          ADD_CTRL = (op_q == OP_SUB);
        end
        if (cnt_q == len - 5'd1) state_d = OUT;
        else                     cnt_d   = cnt_q + 5'd1;
      end
      OUT: begin
        OUT_READY     = 1'b1;
        RES_VALID     = 1'b1;
        ADD_STORE     = (op_q != OP_DOT);
        RES_INDEX     = cnt_q[$clog2(N)-1:0];
        STORE_ADDRESS = cnt_q[$clog2(N)-1:0];
        RES_LAST      = (op_q == OP_DOT) || (cnt_q == len - 5'd1);
        cnt_d         = cnt_q;
        if (RES_READY) begin
          if (RES_LAST) begin
            DONE    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is suppressed while reset is asserted so every output reads 0.
  assign CMD_READY = cmd_ready && RSTN;
  assign DIMEN     = dimen_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_pe_controller.sv
// Scoreboard bench for pe_controller: a memory model answers requests,
// expected addresses/beats are queued at command time and popped on output.
`timescale 1ns/1ps
module tb_pe_controller;

  localparam int unsigned AW = 16;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          CMD_VALID, CMD_READY;
  logic [1:0]    CMD_OP, CMD_DIMEN;
  logic [AW-1:0] CMD_BASE_A, CMD_BASE_B;
  logic          MEM_RD, MEM_GNT;
  logic [AW-1:0] MEM_ADDR;
  logic          RST_ADD, RST_PC, RST_ACC, ADD_RST, MAT_MUX, WRITE_MAT;
  logic          MAC_CTRL, ADD_CTRL, ADD_INC, ADD_STORE, OUT_READY;
  logic [2:0]    latency_counter;
  logic [1:0]    DIMEN;
  logic [3:0]    STORE_ADDRESS, RES_INDEX;
  logic          RES_VALID, RES_READY, RES_LAST, BUSY, DONE, ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pe_controller #(.N(16), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_DIMEN(CMD_DIMEN),
    .CMD_BASE_A(CMD_BASE_A), .CMD_BASE_B(CMD_BASE_B),
    .MEM_RD(MEM_RD), .MEM_GNT(MEM_GNT), .MEM_ADDR(MEM_ADDR),
    .RST_ADD(RST_ADD), .RST_PC(RST_PC), .RST_ACC(RST_ACC), .ADD_RST(ADD_RST),
    .MAT_MUX(MAT_MUX), .WRITE_MAT(WRITE_MAT), .MAC_CTRL(MAC_CTRL), .ADD_CTRL(ADD_CTRL),
    .ADD_INC(ADD_INC), .ADD_STORE(ADD_STORE), .OUT_READY(OUT_READY),
    .latency_counter(latency_counter), .DIMEN(DIMEN), .STORE_ADDRESS(STORE_ADDRESS),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_LAST(RES_LAST), .RES_INDEX(RES_INDEX),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  int unsigned mem [int unsigned];
  int unsigned exp_addr_q [$];
  int unsigned exp_idx_q [$];
  int unsigned a_vec [16];
  int unsigned b_vec [16];
  int          na, nb;

  function automatic int unsigned rd_mem(input int unsigned addr);
    if (mem.exists(addr)) return mem[addr];
    return (addr * 7 + 3) & 32'h00FF;
  endfunction

  function automatic int unsigned exp_dot(input int unsigned ba, input int unsigned bb, input int len);
    int unsigned s = 0;
    for (int i = 0; i < len; i++) s += rd_mem(ba + i) * rd_mem(bb + i);
    return s;
  endfunction

  // Runs one command. gdelay = cycles MEM_RD waits before MEM_GNT (tied=1 holds MEM_GNT high always).
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] dim,
                         input int unsigned ba, input int unsigned bb,
                         input bit tied, input int gdelay,
                         input int stall_beat, input int stall_len, input bit abort_loadb,
                         output int done_cyc, output int unsigned dot_res);
    int len;
    int wait_cnt, cap_due, stall_left, exec_n, wrong_n, done_n;
    int unsigned cap_addr, e;
    bit cap_a, exp_last;
    len = 2 << dim;
    wait_cnt = 0; cap_due = -1; stall_left = stall_len;
    exec_n = 0; wrong_n = 0; done_n = 0; cap_a = 1'b0; cap_addr = 0;
    done_cyc = -1; dot_res = 0; na = 0; nb = 0;
    exp_addr_q.delete(); exp_idx_q.delete();
    for (int i = 0; i < len; i++) exp_addr_q.push_back(ba + i);
    for (int i = 0; i < len; i++) exp_addr_q.push_back(bb + i);
    for (int i = 0; i < ((op == 2'd0) ? 1 : len); i++) exp_idx_q.push_back(i);

    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DIMEN = dim;
    CMD_BASE_A = AW'(ba); CMD_BASE_B = AW'(bb);
    MEM_GNT = tied; RES_READY = 1'b1;
    #1;
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL cmd_accept: CMD_READY=%b BUSY=%b, required 1 0", CMD_READY, BUSY);
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) errors++;

    for (int cyc = 1; cyc <= 600 && done_cyc < 0; cyc++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      if (tied) MEM_GNT = 1'b1;
      else      MEM_GNT = MEM_RD ? (wait_cnt >= gdelay) : cyc[0];
      if (MEM_RD) wait_cnt = MEM_GNT ? 0 : wait_cnt + 1;
      RES_READY = !(RES_VALID && (int'(RES_INDEX) == stall_beat) && stall_left > 0);
      if (!RES_READY) begin
        stall_left--;
        checks++;
        if (STORE_ADDRESS !== 4'(stall_beat) || OUT_READY !== 1'b1 || DONE !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: STORE_ADDRESS=%0d OUT_READY=%b DONE=%b, required %0d 1 0",
                   STORE_ADDRESS, OUT_READY, DONE, stall_beat);
        end
      end
      #1;

      if (abort_loadb && WRITE_MAT && !MAT_MUX) begin
        #1 RSTN = 1'b0;
        #1;
        checks++;
        if (BUSY !== 1'b0 || CMD_READY !== 1'b0 || MEM_RD !== 1'b0 || WRITE_MAT !== 1'b0 ||
            latency_counter !== 3'd0 || DIMEN !== 2'd0) begin
          errors++;
          $display("FAIL reset_async: BUSY=%b CMD_READY=%b MEM_RD=%b WRITE_MAT=%b lat=%0d DIMEN=%0d, required all 0",
                   BUSY, CMD_READY, MEM_RD, WRITE_MAT, latency_counter, DIMEN);
        end
        @(negedge CLK);
        RSTN = 1'b1; MEM_GNT = 1'b0; RES_READY = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge CLK); #1;
          if (DONE) done_n++;
        end
        checks++;
        if (done_n != 0 || BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
          errors++;
          $display("FAIL reset_abandon: DONE pulses=%0d BUSY=%b CMD_READY=%b, required 0 0 1",
                   done_n, BUSY, CMD_READY);
        end
        return;
      end

      if (cyc == 1) begin
        checks++;
        if ({RST_ADD, RST_PC, RST_ACC, ADD_RST, BUSY, WRITE_MAT} !== 6'b111110 || DIMEN !== dim) begin
          errors++;
          $display("FAIL init_pulse: rst/busy/wr=%b DIMEN=%0d, required 111110 %0d",
                   {RST_ADD, RST_PC, RST_ACC, ADD_RST, BUSY, WRITE_MAT}, DIMEN, dim);
        end
      end

      if (MEM_RD) begin
        checks++;
        if (latency_counter !== 3'd0 || WRITE_MAT !== 1'b1) begin
          errors++;
          $display("FAIL req_latency: lat=%0d WRITE_MAT=%b while MEM_RD, required 0 1", latency_counter, WRITE_MAT);
        end
        if (MEM_GNT) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL mem_addr: unexpected request at %h, required none", MEM_ADDR);
          end else begin
            e = exp_addr_q.pop_front();
            if (MEM_ADDR !== AW'(e)) begin
              errors++;
              $display("FAIL mem_addr: got %h, required %h", MEM_ADDR, AW'(e));
            end
          end
          cap_due = cyc + 2; cap_addr = 32'(MEM_ADDR); cap_a = MAT_MUX;
        end
      end

      if (cyc == cap_due - 1) begin
        checks++;
        if (latency_counter !== 3'd1 || MEM_RD !== 1'b0) begin
          errors++;
          $display("FAIL lat_one: lat=%0d MEM_RD=%b, required 1 0", latency_counter, MEM_RD);
        end
      end

      if (cyc == cap_due || latency_counter == 3'd2) begin
        checks++;
        if (cyc != cap_due || latency_counter !== 3'd2 || MEM_RD !== 1'b0) begin
          errors++;
          $display("FAIL capture_timing: cycle %0d lat=%0d, required cycle %0d lat 2", cyc, latency_counter, cap_due);
        end else if (cap_a) begin
          if (na < 16) a_vec[na] = rd_mem(cap_addr);
          na++;
        end else begin
          if (nb < 16) b_vec[nb] = rd_mem(cap_addr);
          nb++;
        end
      end

      if ((op == 2'd0) ? MAC_CTRL : ADD_INC) exec_n++;
      if ((op == 2'd0) ? ADD_INC : MAC_CTRL) wrong_n++;
      if (ADD_INC && ADD_CTRL !== (op == 2'd2)) wrong_n++;

      if (RES_VALID && RES_READY) begin
        checks++;
        if (exp_idx_q.size() == 0) begin
          errors++;
          $display("FAIL res_beat: unexpected beat index %0d, required none", RES_INDEX);
        end else begin
          e = exp_idx_q.pop_front();
          exp_last = (exp_idx_q.size() == 0);
          if (RES_INDEX !== 4'(e) || STORE_ADDRESS !== 4'(e) || RES_LAST !== exp_last ||
              DONE !== exp_last || ADD_STORE !== (op != 2'd0) || OUT_READY !== 1'b1) begin
            errors++;
            $display("FAIL res_beat: idx=%0d sa=%0d last=%b done=%b store=%b, required %0d %0d %b %b %b",
                     RES_INDEX, STORE_ADDRESS, RES_LAST, DONE, ADD_STORE, e, e, exp_last, exp_last, op != 2'd0);
          end
          if (op == 2'd0)
            for (int i = 0; i < len && i < 16; i++) dot_res += a_vec[i] * b_vec[i];
        end
      end

      if (DONE) begin
        done_n++;
        done_cyc = cyc;
      end
    end

    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: no DONE within 600 cycles, required DONE");
    end
    @(negedge CLK); #1;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || CMD_READY !== 1'b1 || RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL return_idle: DONE=%b BUSY=%b CMD_READY=%b RES_VALID=%b, required 0 0 1 0",
               DONE, BUSY, CMD_READY, RES_VALID);
    end
    checks++;
    if (exec_n != len || wrong_n != 0 || na != len || nb != len) begin
      errors++;
      $display("FAIL exec_len: exec=%0d wrong=%0d capA=%0d capB=%0d, required %0d 0 %0d %0d",
               exec_n, wrong_n, na, nb, len, len, len);
    end
    checks++;
    if (exp_addr_q.size() != 0 || exp_idx_q.size() != 0 || done_n != 1) begin
      errors++;
      $display("FAIL scoreboard_drain: addr left=%0d beats left=%0d done pulses=%0d, required 0 0 1",
               exp_addr_q.size(), exp_idx_q.size(), done_n);
    end
  endtask

  // First OUT cycle after accept: INIT + 2*LEN*(3+d) + EXEC(LEN), plus beats/stall.
  function automatic int exp_done(input int len, input int d, input int beats, input int stall);
    return 3 + 2 * len * (3 + d) + len + (beats - 1) + stall;
  endfunction

  task automatic test_reset();
    RSTN = 1'b0; CMD_VALID = 1'b0; CMD_OP = '0; CMD_DIMEN = '0;
    CMD_BASE_A = '0; CMD_BASE_B = '0; MEM_GNT = 1'b0; RES_READY = 1'b0;
    #13;
    checks++;
    if (CMD_READY !== 1'b0 || BUSY !== 1'b0 || MEM_RD !== 1'b0 || MEM_ADDR !== '0 ||
        RES_VALID !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || latency_counter !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: CMD_READY=%b BUSY=%b MEM_RD=%b RES_VALID=%b, required all 0",
               CMD_READY, BUSY, MEM_RD, RES_VALID);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || DIMEN !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: CMD_READY=%b BUSY=%b DIMEN=%0d, required 1 0 0", CMD_READY, BUSY, DIMEN);
    end
  endtask

  task automatic test_dot_basic();
    int dc; int unsigned r;
    mem[32'h10] = 3; mem[32'h11] = 4; mem[32'h20] = 5; mem[32'h21] = 6;
    run_cmd(2'd0, 2'd0, 32'h10, 32'h20, 1'b1, 0, -1, 0, 1'b0, dc, r);
    checks++;
    if (r != 39 || dc != 17) begin
      errors++;
      $display("FAIL dot_basic: result=%0d done_cycle=%0d, required 39 17", r, dc);
    end
  endtask

  task automatic test_sub_sweep();
    int dc; int unsigned r;
    run_cmd(2'd2, 2'd3, 32'h100, 32'h200, 1'b0, 0, -1, 0, 1'b0, dc, r);
    checks++;
    if (dc != exp_done(16, 0, 16, 0)) begin
      errors++;
      $display("FAIL sub_sweep: done_cycle=%0d, required %0d", dc, exp_done(16, 0, 16, 0));
    end
  endtask

  task automatic test_gnt_delay();
    int dc; int unsigned r;
    run_cmd(2'd0, 2'd1, 32'h300, 32'h400, 1'b0, 3, -1, 0, 1'b0, dc, r);
    checks++;
    if (r != exp_dot(32'h300, 32'h400, 4) || dc != exp_done(4, 3, 1, 0)) begin
      errors++;
      $display("FAIL gnt_delay: result=%0d done_cycle=%0d, required %0d %0d",
               r, dc, exp_dot(32'h300, 32'h400, 4), exp_done(4, 3, 1, 0));
    end
  endtask

  task automatic test_back_to_back_stall();
    int dc; int unsigned r;
    run_cmd(2'd1, 2'd1, 32'h500, 32'h600, 1'b0, 0, 2, 4, 1'b0, dc, r);
    checks++;
    if (dc != exp_done(4, 0, 4, 4)) begin
      errors++;
      $display("FAIL add_stall: done_cycle=%0d, required %0d", dc, exp_done(4, 0, 4, 4));
    end
  endtask

  task automatic test_err();
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = 2'd3; CMD_DIMEN = 2'd2;
    #1;
    checks++;
    if (ERR !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: ERR=%b BUSY=%b, required 1 0", ERR, BUSY);
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    #1;
    checks++;
    if (ERR !== 1'b0 || BUSY !== 1'b0 || CMD_READY !== 1'b1 || DIMEN !== 2'd1) begin
      errors++;
      $display("FAIL err_idle: ERR=%b BUSY=%b CMD_READY=%b DIMEN=%0d, required 0 0 1 1",
               ERR, BUSY, CMD_READY, DIMEN);
    end
  endtask

  task automatic test_reset_mid();
    int dc; int unsigned r;
    run_cmd(2'd0, 2'd1, 32'h700, 32'h800, 1'b1, 0, -1, 0, 1'b1, dc, r);
    mem[32'h50] = 7; mem[32'h51] = 2; mem[32'h60] = 1; mem[32'h61] = 3;
    run_cmd(2'd0, 2'd0, 32'h50, 32'h60, 1'b0, 1, -1, 0, 1'b0, dc, r);
    checks++;
    if (r != 13 || dc != exp_done(2, 1, 1, 0)) begin
      errors++;
      $display("FAIL dot_after_reset: result=%0d done_cycle=%0d, required 13 %0d", r, dc, exp_done(2, 1, 1, 0));
    end
  endtask

  initial begin
    test_reset();
    test_dot_basic();
    test_sub_sweep();
    test_gnt_delay();
    test_back_to_back_stall();
    test_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
